// File: rtl/output_tile_writer_pkg.sv
// Shared sizing, FSM encoding and int8 saturation for the output tile writer.
package output_tile_writer_pkg;

    localparam int ARRAYWIDTH = 8;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 8;
    localparam int ADDR_W     = 17;
    localparam int DIM_W      = 11;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > 127)
            return 8'h7F;
        else if (v < -128)
            return 8'h80;
        else
            return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/output_tile_writer_fifo.sv
// Show-ahead synchronous FIFO; a push on a full FIFO succeeds when a pop happens the same cycle.
module writer_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW:0]       r_wr_ptr;
    logic [PW:0]       r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[PW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/output_tile_writer.sv
// Requantizes accumulator beats to int8 and writes them as tiled row-major bytes with edge-tile lane masks.
module output_tile_writer
    import output_tile_writer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIM_W-1:0]            cfg_m,
    input  logic [DIM_W-1:0]            cfg_n,
    input  logic [ADDR_W-1:0]           cfg_base,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_relu,
    input  logic                        in_valid,
    input  logic [ACC_W*ARRAYWIDTH-1:0] in_data,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [OUT_W*ARRAYWIDTH-1:0] wr_data,
    output logic [ARRAYWIDTH-1:0]       wr_mask,
    output logic                        busy,
    output logic                        done,
    output logic                        err_ovf
);
    localparam int COL_W = DIM_W + 1;
    localparam int ENT_W = OUT_W*ARRAYWIDTH + ADDR_W + ARRAYWIDTH;
    localparam logic [COL_W-1:0]  AW_C  = COL_W'(ARRAYWIDTH);
    localparam logic [ADDR_W-1:0] AW_A  = ADDR_W'(ARRAYWIDTH);
    localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);

    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] v,
                                                 input logic [4:0] sh, input logic relu);
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (relu && s < 0) s = '0;
        return sat8(s);
    endfunction

    state_t r_state, w_next;
    logic [DIM_W-1:0]  r_m, r_n, r_p;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_addr, r_col_addr;
    logic [4:0]        r_shift;
    logic              r_relu, r_done, r_err;
    logic              w_run, w_start_ok, w_drain_done, w_out_idle;
    logic              w_push, w_pop, w_drop, w_last_p, w_last_ct, w_last;
    logic              w_empty, w_full;
    logic [OUT_W*ARRAYWIDTH-1:0] w_q_data_p1, w_h_data;
    logic [ARRAYWIDTH-1:0]       w_mask_p1, w_h_mask;
    logic [ADDR_W-1:0]           w_h_addr;
    logic [ENT_W-1:0]            w_fifo_din_p1, w_fifo_dout;
    logic                        r_vld_p2;
    logic [ADDR_W-1:0]           r_wr_addr_p2;
    logic [OUT_W*ARRAYWIDTH-1:0] r_wr_data_p2;
    logic [ARRAYWIDTH-1:0]       r_wr_mask_p2;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)      w_next = ST_RUN;
            ST_RUN:   if (w_last)     w_next = ST_DRAIN;
            ST_DRAIN: if (w_out_idle) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run        = (r_state == ST_RUN);
        w_start_ok   = (r_state == ST_IDLE) && start;
        w_drain_done = (r_state == ST_DRAIN) && w_out_idle;
        busy         = (r_state != ST_IDLE);
    end

    assign w_pop      = !w_empty && (!r_vld_p2 || wr_ready);
    assign w_out_idle = w_empty && (!r_vld_p2 || wr_ready);
    assign w_push     = in_valid && w_run && (!w_full || w_pop);
    assign w_drop     = in_valid && !w_push;
    assign w_last_p   = (r_p == r_m - ONE_D);
    assign w_last_ct  = ((r_col + AW_C) >= {1'b0, r_n});
    assign w_last     = w_push && w_last_p && w_last_ct;

    // Stage 1: requantize lanes and tag with tile address/mask; the FIFO entry is the stage register
    always_comb begin
        w_q_data_p1 = '0;
        w_mask_p1   = '0;
        for (int i = 0; i < ARRAYWIDTH; i++) begin
            w_q_data_p1[i*OUT_W +: OUT_W] = requant($signed(in_data[i*ACC_W +: ACC_W]), r_shift, r_relu);
            w_mask_p1[i] = (r_col + COL_W'(i)) < {1'b0, r_n};
        end
    end
    assign w_fifo_din_p1 = {w_q_data_p1, r_addr, w_mask_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= '0; r_n <= '0; r_shift <= '0; r_relu <= 1'b0;
            r_p <= '0; r_col <= '0; r_addr <= '0; r_col_addr <= '0;
        end else if (w_start_ok) begin
            r_m <= cfg_m; r_n <= cfg_n; r_shift <= cfg_shift; r_relu <= cfg_relu;
            r_p <= '0; r_col <= '0; r_addr <= cfg_base; r_col_addr <= cfg_base;
        end else if (w_push) begin
            if (w_last_p) begin
                r_p        <= '0;
                r_col      <= r_col + AW_C;
                r_col_addr <= r_col_addr + AW_A;
                r_addr     <= r_col_addr + AW_A;
            end else begin
                r_p    <= r_p + ONE_D;
                r_addr <= r_addr + ADDR_W'(r_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_drain_done;
            if (w_drop)          r_err <= 1'b1;
            else if (w_start_ok) r_err <= 1'b0;
        end
    end

    writer_fifo #(.DATA_W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din_p1),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full)
    );
    assign {w_h_data, w_h_addr, w_h_mask} = w_fifo_dout;

    // Stage 2: write-port register, held while the memory stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2     <= 1'b0;
            r_wr_addr_p2 <= '0;
            r_wr_data_p2 <= '0;
            r_wr_mask_p2 <= '0;
        end else if (w_pop) begin
            r_vld_p2     <= 1'b1;
            r_wr_addr_p2 <= w_h_addr;
            r_wr_data_p2 <= w_h_data;
            r_wr_mask_p2 <= w_h_mask;
        end else if (wr_ready) begin
            r_vld_p2 <= 1'b0;
        end
    end

    assign wr_valid = r_vld_p2;
    assign wr_addr  = r_wr_addr_p2;
    assign wr_data  = r_wr_data_p2;
    assign wr_mask  = r_wr_mask_p2;
    assign done     = r_done;
    assign err_ovf  = r_err;

endmodule

// File: tb/tb_output_tile_writer.sv
// Directed bench for output_tile_writer: tiling order, edge masks, requantization, backpressure, reset.
module tb_output_tile_writer;
    import output_tile_writer_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst, start, cfg_relu, in_valid, wr_ready;
    logic [DIM_W-1:0]            cfg_m, cfg_n;
    logic [ADDR_W-1:0]           cfg_base;
    logic [4:0]                  cfg_shift;
    logic [ACC_W*ARRAYWIDTH-1:0] in_data;
    logic                        wr_valid, busy, done, err_ovf;
    logic [ADDR_W-1:0]           wr_addr;
    logic [OUT_W*ARRAYWIDTH-1:0] wr_data;
    logic [ARRAYWIDTH-1:0]       wr_mask;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0]           cap_addr [$];
    logic [OUT_W*ARRAYWIDTH-1:0] cap_data [$];
    logic [ARRAYWIDTH-1:0]       cap_mask [$];

    output_tile_writer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n),
        .cfg_base(cfg_base), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_data(in_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            cap_mask.push_back(wr_mask);
        end
        if (done) done_cnt++;
    end

    function automatic logic [255:0] pack8(input int l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [255:0] splat(input int v);
        return pack8(v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [63:0] bytes8(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {8{b}};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int m, input int n, input int base, input int sh, input int relu);
        cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_base = ADDR_W'(base);
        cfg_shift = 5'(sh); cfg_relu = relu[0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [255:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int k = 0;
        while (done_cnt == d0 && k < 60) begin tick(); k++; end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s done_timeout: done_cnt=%0d required>%0d", name, done_cnt, d0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; in_data = '0;
        cfg_m = '0; cfg_n = '0; cfg_base = '0; cfg_shift = '0; cfg_relu = 1'b0;
        tick(); tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (wr_mask !== '0) begin errors++; $display("FAIL reset_wr_mask got %h want 0", wr_mask); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n0 = cap_addr.size();
        int d0 = done_cnt;
        wr_ready = 1'b1;
        do_start(3, 8, 'h100, 0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        in_valid = 1'b1; in_data = pack8(0, 1, 2, 3, 4, 5, 6, 7);
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 wr_valid got %b want 0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1 || wr_addr !== 17'h100) begin
            errors++; $display("FAIL basic_lat2 wr_valid/addr got %b/%h want 1/100", wr_valid, wr_addr); end
        tick();
        in_valid = 1'b0;
        wait_done(d0, "basic");
        tick(); tick(); tick();
        checks++; if (cap_addr.size() !== n0 + 3) begin
            errors++; $display("FAIL basic_count got %0d want 3", cap_addr.size() - n0); end
        for (int i = 0; i < 3 && n0 + i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[n0+i] !== ADDR_W'('h100 + 8*i) || cap_mask[n0+i] !== 8'hFF ||
                cap_data[n0+i] !== 64'h0706050403020100) begin
                errors++;
                $display("FAIL basic_write%0d got addr=%h mask=%h data=%h want addr=%h mask=ff data=0706050403020100",
                         i, cap_addr[n0+i], cap_mask[n0+i], cap_data[n0+i], 'h100 + 8*i);
            end
        end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_edge_tile();
        int n0 = cap_addr.size();
        int d0 = done_cnt;
        int exp_addr [4] = '{0, 10, 8, 18};
        logic [7:0] exp_mask [4] = '{8'hFF, 8'hFF, 8'h03, 8'h03};
        do_start(2, 10, 0, 0, 0);
        for (int k = 0; k < 4; k++) beat(splat(k + 1));
        wait_done(d0, "edge");
        tick();
        checks++; if (cap_addr.size() !== n0 + 4) begin
            errors++; $display("FAIL edge_count got %0d want 4", cap_addr.size() - n0); end
        for (int i = 0; i < 4 && n0 + i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[n0+i] !== ADDR_W'(exp_addr[i]) || cap_mask[n0+i] !== exp_mask[i] ||
                cap_data[n0+i] !== bytes8(i + 1)) begin
                errors++;
                $display("FAIL edge_write%0d got addr=%h mask=%h data=%h want addr=%h mask=%h data=%h",
                         i, cap_addr[n0+i], cap_mask[n0+i], cap_data[n0+i], exp_addr[i], exp_mask[i], bytes8(i + 1));
            end
        end
    endtask

    task automatic run_sat(input int sh, input int relu, input logic [255:0] d,
                           input logic [63:0] expd, input string name);
        int n0 = cap_addr.size();
        int d0 = done_cnt;
        do_start(1, 8, 'h200, sh, relu);
        beat(d);
        wait_done(d0, name);
        tick();
        checks++;
        if (cap_addr.size() !== n0 + 1 || cap_data[n0] !== expd) begin
            errors++;
            $display("FAIL %s writes=%0d data=%h want writes=1 data=%h", name, cap_addr.size() - n0,
                     (cap_addr.size() > n0) ? cap_data[n0] : 64'h0, expd);
        end
    endtask

    task automatic test_saturation();
        run_sat(0, 0, pack8(1000, -1000, 5, -5, 127, 128, -128, -129), 64'h80807F7FFB05807F, "sat_clip");
        run_sat(4, 0, pack8('h50, -'h50, -1, 'h7FFFFFFF, 'h8F, 0, 0, 0), 64'h000000087FFFFB05, "sat_shift");
        run_sat(0, 1, pack8(-7, 7, -1000, 1000, 0, -1, 3, 200), 64'h7F0300007F000700, "sat_relu");
    endtask

    task automatic test_backpressure();
        int n0 = cap_addr.size();
        int d0 = done_cnt;
        wr_ready = 1'b0;
        do_start(8, 8, 0, 0, 0);
        for (int k = 0; k < 6; k++) beat(splat(k));
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL bp_err got %b want 1", err_ovf); end
        checks++; if (wr_valid !== 1'b1 || wr_addr !== '0 || wr_data !== bytes8(0)) begin
            errors++; $display("FAIL bp_hold got v=%b addr=%h data=%h want v=1 addr=0 data=0", wr_valid, wr_addr, wr_data); end
        checks++; if (cap_addr.size() !== n0) begin errors++; $display("FAIL bp_stall_writes got %0d want 0", cap_addr.size() - n0); end
        wr_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        checks++; if (cap_addr.size() !== n0 + 5) begin
            errors++; $display("FAIL bp_drained got %0d want 5", cap_addr.size() - n0); end
        for (int k = 5; k < 8; k++) beat(splat(k));
        wait_done(d0, "bp");
        tick();
        checks++; if (cap_addr.size() !== n0 + 8) begin
            errors++; $display("FAIL bp_total got %0d want 8", cap_addr.size() - n0); end
        for (int i = 0; i < 8 && n0 + i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[n0+i] !== ADDR_W'(8*i) || cap_data[n0+i] !== bytes8(i)) begin
                errors++;
                $display("FAIL bp_write%0d got addr=%h data=%h want addr=%h data=%h",
                         i, cap_addr[n0+i], cap_data[n0+i], 8*i, bytes8(i));
            end
        end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL bp_err_sticky got %b want 1", err_ovf); end
    endtask

    task automatic test_idle_and_start_ignored();
        int n0;
        int d0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        n0 = cap_addr.size();
        d0 = done_cnt;
        wr_ready = 1'b1;
        beat(splat(9));
        tick(); tick();
        checks++; if (err_ovf !== 1'b1 || cap_addr.size() !== n0) begin
            errors++; $display("FAIL idle_drop got err=%b writes=%0d want err=1 writes=0", err_ovf, cap_addr.size() - n0); end
        do_start(2, 8, 'h40, 0, 0);
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL start_clears_err got %b want 0", err_ovf); end
        beat(splat(1));
        cfg_m = DIM_W'(1); cfg_n = DIM_W'(16); cfg_base = ADDR_W'('h500);
        start = 1'b1; in_valid = 1'b1; in_data = splat(2);
        tick();
        start = 1'b0; in_valid = 1'b0;
        wait_done(d0, "restart");
        tick();
        checks++;
        if (cap_addr.size() !== n0 + 2 || cap_addr[n0] !== 17'h40 || cap_addr[n0+1] !== 17'h48 ||
            cap_mask[n0+1] !== 8'hFF) begin
            errors++;
            $display("FAIL start_ignored writes=%0d want 2 at 40,48 mask ff", cap_addr.size() - n0);
        end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_midop();
        int n0;
        int d0;
        wr_ready = 1'b0;
        do_start(4, 8, 0, 0, 0);
        beat(splat(3));
        tick();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got wr_valid=%b want 1", wr_valid); end
        n0 = cap_addr.size();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_clear got v=%b busy=%b want 0/0", wr_valid, busy); end
        rst = 1'b0; wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++; if (done_cnt !== d0 || cap_addr.size() !== n0 || wr_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet got done=%0d writes=%0d v=%b want 0/0/0",
                               done_cnt - d0, cap_addr.size() - n0, wr_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_tile();
        test_saturation();
        test_backpressure();
        test_idle_and_start_ignored();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
